// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter sequencing for the fetch stage.
// Resolves branch, jump and jump-register redirects from execute, holds the
// PC on stall, and raises Flush for FLUSH_CYCLES cycles after each redirect.
// A saturating redirect counter is kept for performance debug.
// Resolve inputs are sampled only while the sequencer is in RUN. In FLUSH
// they belong to squashed instructions and are ignored.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        ResolveValid,
  input  logic [1:0]  BranchType,
  input  logic        BranchTaken,
  input  logic [31:0] ResolvePC,
  input  logic [31:0] BranchOffset,
  input  logic [25:0] JumpIndex,
  input  logic [31:0] RegTarget,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        Flush,
  output logic        Misaligned,
  output logic [15:0] RedirectCount
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [1:0] BT_NONE   = 2'd0;
  localparam logic [1:0] BT_JUMP   = 2'd1;
  localparam logic [1:0] BT_JREG   = 2'd2;
  localparam logic [1:0] BT_BRANCH = 2'd3;

  // The counter is loaded with the number of flush cycles still to go after
  // the first one.
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [2:0]  flush_cnt;
  logic [15:0] redirect_cnt;
  logic        redirect;
  logic [31:0] target;

  assign PCPlus4       = PC + 32'd4;
  assign RedirectCount = redirect_cnt;

  // Decode the redirect condition and select the target address.
  always_comb begin
    redirect = 1'b0;
    target   = PCPlus4;
    if (ResolveValid && (state == RUN)) begin
      case (BranchType)
        BT_JUMP: begin
          redirect = 1'b1;
          target   = {ResolvePC[31:28], JumpIndex, 2'b00};
        end
        BT_JREG: begin
          redirect = 1'b1;
          target   = {RegTarget[31:2], 2'b00};
        end
        BT_BRANCH: begin
          redirect = BranchTaken;
          target   = ResolvePC + {BranchOffset[29:0], 2'b00};
        end
        default: begin
          redirect = 1'b0;
          target   = PCPlus4;
        end
      endcase
    end
  end

  // RUN/FLUSH sequencer: owns PC, Flush, Misaligned and the flush counter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= RUN;
      PC         <= RESET_PC;
      Flush      <= 1'b0;
      Misaligned <= 1'b0;
      flush_cnt  <= 3'd0;
    end else begin
      case (state)
        RUN: begin
          if (redirect) begin
            // A redirect overrides a same-cycle stall.
            PC         <= target;
            state      <= FLUSH;
            Flush      <= 1'b1;
            flush_cnt  <= FLUSH_INIT;
            Misaligned <= (BranchType == BT_JREG) && (RegTarget[1:0] != 2'b00);
          end else begin
            Misaligned <= 1'b0;
            if (!Stall) PC <= PCPlus4;
          end
        end
        FLUSH: begin
          Misaligned <= 1'b0;
          if (!Stall) PC <= PCPlus4;
          if (flush_cnt == 3'd0) begin
            state <= RUN;
            Flush <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
          end
        end
        default: begin
          state <= RUN;
          Flush <= 1'b0;
        end
      endcase
    end
  end

  // Saturating redirect counter. It is written only on reset or a redirect.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      redirect_cnt <= 16'd0;
    end else if (redirect && (redirect_cnt != 16'hFFFF)) begin
      redirect_cnt <= redirect_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer. Two instances share the stimulus:
// u_dut1 uses FLUSH_CYCLES=1 and RESET_PC=0.
// u_dut3 uses FLUSH_CYCLES=3 and RESET_PC=0x100.
// Each instance has its own reset, so one can be parked while the other runs.
// Expected values are queued as each step is driven. They are popped and
// compared one time unit after the next rising edge.
module tb_pc_sequencer;

  logic        clk;
  logic        rst1, rst3;
  logic        stall, rv, tk;
  logic [1:0]  bt;
  logic [31:0] rpc, off, rt;
  logic [25:0] ji;

  logic [31:0] pc1, pc4_1, pc3, pc4_3;
  logic        fl1, mis1, fl3, mis3;
  logic [15:0] cnt1, cnt3;

  logic [31:0] exp_q[$];
  int          kind_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          passed = 0;

  localparam int K_PC = 0, K_PC4 = 1, K_FL = 2, K_MIS = 3, K_CNT = 4;
  localparam int K_D3 = 10;

  pc_sequencer #(.RESET_PC(32'h0000_0000), .FLUSH_CYCLES(1)) u_dut1 (
    .Clk(clk), .Reset(rst1), .Stall(stall), .ResolveValid(rv),
    .BranchType(bt), .BranchTaken(tk), .ResolvePC(rpc),
    .BranchOffset(off), .JumpIndex(ji), .RegTarget(rt),
    .PC(pc1), .PCPlus4(pc4_1), .Flush(fl1), .Misaligned(mis1),
    .RedirectCount(cnt1)
  );

  pc_sequencer #(.RESET_PC(32'h0000_0100), .FLUSH_CYCLES(3)) u_dut3 (
    .Clk(clk), .Reset(rst3), .Stall(stall), .ResolveValid(rv),
    .BranchType(bt), .BranchTaken(tk), .ResolvePC(rpc),
    .BranchOffset(off), .JumpIndex(ji), .RegTarget(rt),
    .PC(pc3), .PCPlus4(pc4_3), .Flush(fl3), .Misaligned(mis3),
    .RedirectCount(cnt3)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input int k);
    case (k)
      K_PC:         return pc1;
      K_PC4:        return pc4_1;
      K_FL:         return {31'd0, fl1};
      K_MIS:        return {31'd0, mis1};
      K_CNT:        return {16'd0, cnt1};
      K_D3 + K_PC:  return pc3;
      K_D3 + K_PC4: return pc4_3;
      K_D3 + K_FL:  return {31'd0, fl3};
      K_D3 + K_MIS: return {31'd0, mis3};
      K_D3 + K_CNT: return {16'd0, cnt3};
      default:      return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string tag, input int k, input logic [31:0] v);
    tag_q.push_back(tag);
    kind_q.push_back(k);
    exp_q.push_back(v);
  endtask

  // Queue the full expected output set of one instance.
  task automatic expect_all(input int base, input string who, input logic [31:0] pc,
                            input logic fl, input logic mis, input logic [15:0] cnt);
    push({who, ".pc"},    base + K_PC,  pc);
    push({who, ".pc4"},   base + K_PC4, pc + 32'd4);
    push({who, ".flush"}, base + K_FL,  {31'd0, fl});
    push({who, ".mis"},   base + K_MIS, {31'd0, mis});
    push({who, ".cnt"},   base + K_CNT, {16'd0, cnt});
  endtask

  task automatic chk1(input logic [31:0] pc, input logic fl, input logic mis,
                      input logic [15:0] cnt);
    expect_all(0, "d1", pc, fl, mis, cnt);
  endtask

  task automatic chk3(input logic [31:0] pc, input logic fl, input logic mis,
                      input logic [15:0] cnt);
    expect_all(K_D3, "d3", pc, fl, mis, cnt);
  endtask

  // Scoreboard: pop every queued expectation and compare it with the DUT.
  task automatic drain();
    logic [31:0] e, o;
    int          k;
    string       t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      k = kind_q.pop_front();
      t = tag_q.pop_front();
      o = observe(k);
      checks++;
      assert (o === e) passed++;
      else $error("FAIL %s got %h expected %h", t, o, e);
    end
  endtask

  // Advance one clock, then compare away from the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic idle();
    rv    = 1'b0;
    bt    = 2'd0;
    tk    = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    rst1 = 1'b1; rst3 = 1'b1;
    idle();
    rpc = '0; off = '0; rt = '0; ji = '0;
    #2;
    chk1(32'h0, 0, 0, 0);
    chk3(32'h100, 0, 0, 0);
    drain();

    // Free running from reset.
    @(posedge clk); #1;
    rst1 = 1'b0;
    chk1(32'h0, 0, 0, 0); drain();
    chk1(32'h4, 0, 0, 0); cyc();
    chk1(32'h8, 0, 0, 0); cyc();
    chk1(32'hC, 0, 0, 0); cyc();

    // Asynchronous reset mid-run is visible before the next edge.
    rst1 = 1'b1; #2;
    chk1(32'h0, 0, 0, 0); drain();
    rst1 = 1'b0;
    chk1(32'h4, 0, 0, 0); cyc();

    // Taken conditional branch with a negative offset.
    rv = 1; bt = 2'd3; tk = 1; rpc = 32'h40; off = 32'hFFFF_FFFC;
    chk1(32'h30, 1, 0, 1); cyc();
    idle();
    chk1(32'h34, 0, 0, 1); cyc();

    // Not-taken branch: no redirect, no flush, no count.
    rv = 1; bt = 2'd3; tk = 0;
    chk1(32'h38, 0, 0, 1); cyc();

    // Jump with a same-cycle stall: the target still wins.
    rv = 1; bt = 2'd1; rpc = 32'h1000_0008; ji = 26'h000_0100; stall = 1;
    chk1(32'h1000_0400, 1, 0, 2); cyc();
    rv = 0; bt = 2'd0;
    chk1(32'h1000_0400, 0, 0, 2); cyc();
    stall = 0;
    chk1(32'h1000_0404, 0, 0, 2); cyc();

    // Misaligned jump-register target is masked and flagged for one cycle.
    rv = 1; bt = 2'd2; rt = 32'h0000_0203; tk = 0;
    chk1(32'h200, 1, 1, 3); cyc();
    idle();
    chk1(32'h204, 0, 0, 3); cyc();

    // Type 0 ignores BranchTaken.
    rv = 1; bt = 2'd0; tk = 1;
    chk1(32'h208, 0, 0, 3); cyc();
    idle();

    // Four stalled cycles in RUN.
    stall = 1;
    for (int i = 0; i < 4; i++) begin
      chk1(32'h208, 0, 0, 3); cyc();
    end
    stall = 0;

    // PC wrap while flushing and while running.
    rv = 1; bt = 2'd2; rt = 32'hFFFF_FFFC;
    chk1(32'hFFFF_FFFC, 1, 0, 4); cyc();
    idle();
    chk1(32'h0, 0, 0, 4); cyc();
    rv = 1; bt = 2'd2; rt = 32'hFFFF_FFF8;
    chk1(32'hFFFF_FFF8, 1, 0, 5); cyc();
    idle();
    chk1(32'hFFFF_FFFC, 0, 0, 5); cyc();
    chk1(32'h0, 0, 0, 5); cyc();

    // Branch target arithmetic wraps at 32 bits.
    rv = 1; bt = 2'd3; tk = 1; rpc = 32'hFFFF_FFF0; off = 32'h8;
    chk1(32'h10, 1, 0, 6); cyc();
    idle();
    chk1(32'h14, 0, 0, 6); cyc();

    // Reset asserted mid-flush clears everything immediately.
    rv = 1; bt = 2'd1; rpc = 32'h0; ji = 26'h40;
    chk1(32'h100, 1, 0, 7); cyc();
    idle();
    rst1 = 1'b1; #2;
    chk1(32'h0, 0, 0, 0); drain();
    rst1 = 1'b0;
    chk1(32'h4, 0, 0, 0); cyc();

    // Saturation: preload the counter near the top instead of running 65k redirects.
    force u_dut1.redirect_cnt = 16'hFFFD;
    #1;
    release u_dut1.redirect_cnt;
    rv = 1; bt = 2'd1; rpc = 32'h0; ji = 26'h0;
    chk1(32'h0, 1, 0, 16'hFFFE); cyc();
    idle();
    chk1(32'h4, 0, 0, 16'hFFFE); cyc();
    rv = 1; bt = 2'd1;
    chk1(32'h0, 1, 0, 16'hFFFF); cyc();
    idle();
    chk1(32'h4, 0, 0, 16'hFFFF); cyc();
    rv = 1; bt = 2'd1;
    chk1(32'h0, 1, 0, 16'hFFFF); cyc();
    idle();
    chk1(32'h4, 0, 0, 16'hFFFF); cyc();
    rst1 = 1'b1;

    // FLUSH_CYCLES=3 instance: Flush lasts three cycles and resolves are ignored.
    rst3 = 1'b0;
    chk3(32'h100, 0, 0, 0); drain();
    chk3(32'h104, 0, 0, 0); cyc();
    rv = 1; bt = 2'd2; rt = 32'h0000_0203;
    chk3(32'h200, 1, 1, 1); cyc();
    rv = 1; bt = 2'd3; tk = 1; rpc = 32'h40; off = 32'hFFFF_FFFC;
    chk3(32'h204, 1, 0, 1); cyc();
    chk3(32'h208, 1, 0, 1); cyc();
    idle();
    chk3(32'h20C, 0, 0, 1); cyc();
    rv = 1; bt = 2'd3; tk = 1;
    chk3(32'h30, 1, 0, 2); cyc();
    idle();
    chk3(32'h34, 1, 0, 2); cyc();
    chk3(32'h38, 1, 0, 2); cyc();
    chk3(32'h3C, 0, 0, 2); cyc();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Consumes the decoder's BranchType code plus the ALU branch-condition result and drives the program counter for the datapath. Computes branch, jump and jump-register targets, holds PC on stall, and issues a multi-cycle Flush to the fetch/decode stages after every redirect. Sits between the execute-stage branch resolution and the instruction memory address port. Keeps a saturating redirect counter for performance debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
FLUSH_CYCLES, 1, cycles Flush stays high after a redirect (legal 1..7)

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
Stall  input  1  hold PC this cycle (hazard unit)
ResolveValid  input  1  branch/jump inputs below are valid this cycle
BranchType  input  2  0 none, 1 jump (j/jal), 2 jump register, 3 conditional branch
BranchTaken  input  1  ALU branch condition result; used only when BranchType==3
ResolvePC  input  32  PC+4 of the resolving instruction
BranchOffset  input  32  sign-extended 16-bit immediate
JumpIndex  input  26  instruction bits [25:0]
RegTarget  input  32  rs register value for jr
PC  output  32  current fetch address
PCPlus4  output  32  PC + 4, combinational
Flush  output  1  squash younger instructions
Misaligned  output  1  one-cycle pulse: jr target low bits nonzero
RedirectCount  output  16  saturating count of redirects

Behaviour:
- Reset (async, any time, including mid-flush): PC=RESET_PC, state=RUN, Flush=0, Misaligned=0, RedirectCount=0, flush counter=0.
- Redirect event = ResolveValid && state==RUN && (BranchType==1 || BranchType==2 || (BranchType==3 && BranchTaken)).
- Targets: type 1 -> {ResolvePC[31:28], JumpIndex, 2'b00}; type 2 -> {RegTarget[31:2], 2'b00}; type 3 -> ResolvePC + (BranchOffset << 2), 32-bit wrap, no overflow detection.
- Misaligned: registered; asserts one cycle after a type-2 redirect whose RegTarget[1:0]!=0; redirect still proceeds to the masked target.
- States: RUN, FLUSH.
  - RUN, redirect event: next edge PC<=target, state<=FLUSH, flush counter<=FLUSH_CYCLES-1, RedirectCount increments (holds at 16'hFFFF).
  - RUN, no redirect, Stall=0: PC<=PC+4. Stall=1: PC holds.
  - Redirect has priority over Stall (same-cycle: PC takes target).
  - FLUSH: Flush=1 (registered, Moore output, high exactly FLUSH_CYCLES cycles starting the edge after redirect). ResolveValid ignored (squashed instructions). PC advances by 4 each cycle unless Stall. Counter==0 -> state<=RUN next edge; else decrement.
- BranchType==3 with BranchTaken=0 or BranchType==0: no redirect, no flush, no count.
- BranchTaken ignored for types 0,1,2.
- PC+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.
- Latency: redirect visible on PC one edge after the resolving cycle.

Test Plan:
- Reset, run 3 cycles, Stall=0 -> PC 0,4,8,12; Flush=0; RedirectCount=0; assert Reset mid-run -> PC=0 immediately (before edge).
- ResolveValid=1, BranchType=3, BranchTaken=1, ResolvePC=32'h40, BranchOffset=32'hFFFF_FFFC -> next PC=32'h30, Flush=1 for 1 cycle, RedirectCount=1; same with BranchTaken=0 -> PC=prev+4, no Flush.
- BranchType=1, ResolvePC=32'h1000_0008, JumpIndex=26'h0000100 -> PC=32'h1000_0400; Stall=1 same cycle -> target still taken.
- BranchType=2, RegTarget=32'h0000_0203 -> PC=32'h0000_0200, Misaligned pulses 1 cycle; FLUSH_CYCLES=3 build -> Flush high 3 cycles, ResolveValid taken-branch during flush ignored (PC keeps +4, count unchanged).
- Stall=1 for 4 cycles in RUN -> PC constant; PC=32'hFFFF_FFFC, no stall -> PC=0.
- Force 65536 redirects -> RedirectCount saturates at 16'hFFFF.
